// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix streaming blocks: default element width,
// streamer state encodings and a constant-foldable ceiling log2.
package matrix_pkg;

   localparam int DW_DEFAULT = 16;

   typedef enum logic [0:0] {
      STATE_IDLE   = 1'b0,
      STATE_STREAM = 1'b1
   } state_e;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((32'sd1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/matrix_col_gather.sv
// Selects one column of a row-major flat matrix as a ROWS-element vector,
// row 0 in the most significant slot; an out-of-range index yields zero.
module matrix_col_gather
   import matrix_pkg::*;
#(
   parameter int DW   = DW_DEFAULT,
   parameter int ROWS = 16,
   parameter int COLS = 10,
   parameter int IW   = 5
) (
   input  logic [ROWS*COLS*DW-1:0] mat_i,
   input  logic [IW-1:0]           col_idx_i,
   output logic [ROWS*DW-1:0]      col_vec_o
);

   logic [ROWS*DW-1:0] vec_s;

   // OR-reduce the masked columns so no index match leaves the vector at zero
   always_comb begin
      vec_s = '0;
      for (int c = 0; c < COLS; c++) begin
         for (int r = 0; r < ROWS; r++) begin
            vec_s[(ROWS-1-r)*DW +: DW] = vec_s[(ROWS-1-r)*DW +: DW] |
               ({DW{col_idx_i == IW'(c)}} & mat_i[(ROWS*COLS-1-(r*COLS+c))*DW +: DW]);
         end
      end
   end

   assign col_vec_o = vec_s;

endmodule

// File: rtl/matrix_col_streamer.sv
// Captures a ROWS x COLS matrix in one handshake and streams it back out
// transposed, LANES column vectors per beat, with back-to-back capture.
module matrix_col_streamer
   import matrix_pkg::*;
#(
   parameter int DW    = DW_DEFAULT,
   parameter int ROWS  = 16,
   parameter int COLS  = 10,
   parameter int LANES = 10,
   localparam int NBEATS = (COLS + LANES - 1) / LANES,
   localparam int BW     = (clog2(NBEATS) > 1) ? clog2(NBEATS) : 1,
   localparam int CW     = (clog2(COLS) > 1) ? clog2(COLS) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ROWS*COLS*DW-1:0]   in_matrix,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*ROWS*DW-1:0]  out_cols,
   output logic [CW-1:0]             out_col_base,
   output logic                      out_last,
   output logic                      done
);

   // One extra bit so base+lane on a partial last beat can exceed COLS-1
   localparam int IW = CW + 1;

   state_e                    state_q, state_d;
   logic [BW-1:0]             beat_q, beat_d;
   logic [ROWS*COLS*DW-1:0]   mat_q, mat_d;
   logic                      done_q, done_d;

   logic [IW-1:0]             base_s;
   logic                      last_s;
   logic                      in_hs_s;
   logic                      out_hs_s;
   logic [LANES*ROWS*DW-1:0]  cols_s;

   assign base_s       = IW'(beat_q) * IW'(LANES);
   assign last_s       = (beat_q == BW'(NBEATS - 1));
   assign out_valid    = !rst && (state_q == STATE_STREAM);
   assign in_ready     = !rst && ((state_q == STATE_IDLE) || (out_valid && out_ready && last_s));
   assign in_hs_s      = in_valid && in_ready;
   assign out_hs_s     = out_valid && out_ready;
   assign out_col_base = base_s[CW-1:0];
   assign out_last     = last_s;
   assign out_cols     = (state_q == STATE_STREAM) ? cols_s : '0;
   assign done         = done_q;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      matrix_col_gather #(
         .DW   (DW),
         .ROWS (ROWS),
         .COLS (COLS),
         .IW   (IW)
      ) u_gather (
         .mat_i     (mat_q),
         .col_idx_i (base_s + IW'(l)),
         .col_vec_o (cols_s[(LANES-1-l)*ROWS*DW +: ROWS*DW])
      );
   end

   // Next-state: capture, beat advance, and zero-bubble recapture on the last beat
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      mat_d   = mat_q;
      done_d  = 1'b0;
      case (state_q)
         STATE_IDLE: begin
            if (in_hs_s) begin
               state_d = STATE_STREAM;
               mat_d   = in_matrix;
               beat_d  = '0;
            end else begin
               state_d = STATE_IDLE;
            end
         end
         STATE_STREAM: begin
            if (out_hs_s && last_s) begin
               done_d = 1'b1;
               beat_d = '0;
               if (in_hs_s) begin
                  mat_d = in_matrix;
               end else begin
                  state_d = STATE_IDLE;
               end
            end else if (out_hs_s) begin
               beat_d = beat_q + BW'(1);
            end else begin
               state_d = STATE_STREAM;
            end
         end
         default: begin
            state_d = STATE_IDLE;
            beat_d  = '0;
         end
      endcase
   end

   // State, beat counter, buffer and done pulse registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= STATE_IDLE;
         beat_q  <= '0;
         mat_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         mat_q   <= mat_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_matrix_col_streamer.sv
// Self-checking bench: default geometry (one beat) and LANES=4 (three beats),
// directed tables, back-to-back and reset corners, then randomized traffic.
module tb_matrix_col_streamer;

   localparam int DW   = 16;
   localparam int ROWS = 16;
   localparam int COLS = 10;
   localparam int MW   = ROWS * COLS * DW;
   localparam int LW   = ROWS * DW;
   localparam int WA   = 10 * LW;
   localparam int WB   = 4 * LW;

   typedef logic [DW-1:0] mat_t [ROWS][COLS];

   typedef struct {
      logic       rdy;
      logic       exp_valid;
      logic       exp_in_ready;
      logic [3:0] exp_base;
      logic       exp_last;
      logic       exp_done;
      int         exp_beat;
   } vec_t;

   typedef struct {
      logic [WB-1:0] cols;
      logic [3:0]    base;
      logic          last;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_done;
   logic [MW-1:0] a_in_matrix;
   logic [WA-1:0] a_out_cols;
   logic [3:0]    a_out_col_base;
   logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_done;
   logic [MW-1:0] b_in_matrix;
   logic [WB-1:0] b_out_cols;
   logic [3:0]    b_out_col_base;

   matrix_col_streamer #(.DW(DW), .ROWS(ROWS), .COLS(COLS), .LANES(10)) dut_a (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_matrix(a_in_matrix), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_cols(a_out_cols), .out_col_base(a_out_col_base), .out_last(a_out_last),
      .done(a_done)
   );

   matrix_col_streamer #(.DW(DW), .ROWS(ROWS), .COLS(COLS), .LANES(4)) dut_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_matrix(b_in_matrix), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_cols(b_out_cols), .out_col_base(b_out_col_base), .out_last(b_out_last),
      .done(b_done)
   );

   int checks = 0;
   int errors = 0;

   function automatic logic [MW-1:0] pack(input mat_t m);
      logic [MW-1:0] v;
      v = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            v[(ROWS*COLS-1-(r*COLS+c))*DW +: DW] = m[r][c];
      return v;
   endfunction

   // Transposed beat b of matrix m for the given lane count, packed at the bottom
   function automatic logic [WA-1:0] beat_vec(input mat_t m, input int b, input int lanes);
      logic [WA-1:0] v;
      int col;
      v = '0;
      for (int l = 0; l < lanes; l++) begin
         col = b * lanes + l;
         if (col < COLS)
            for (int r = 0; r < ROWS; r++)
               v[(lanes-1-l)*LW + (ROWS-1-r)*DW +: DW] = m[r][col];
      end
      return v;
   endfunction

   function automatic mat_t pattern(input logic [15:0] offs);
      mat_t m;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            m[r][c] = {8'(r), 8'(c)} + offs;
      return m;
   endfunction

   function automatic mat_t rand_mat();
      mat_t m;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            m[r][c] = 16'($urandom);
      return m;
   endfunction

   function automatic logic [WA-1:0] widen_b(input logic [WB-1:0] v);
      logic [WA-1:0] w;
      w = '0;
      w[WB-1:0] = v;
      return w;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_cols(input string name, input logic [WA-1:0] act, input logic [WA-1:0] exp);
      int slot;
      checks++;
      if (act !== exp) begin
         errors++;
         slot = 0;
         for (int i = WA/DW - 1; i >= 0; i--)
            if (act[i*DW +: DW] !== exp[i*DW +: DW]) slot = i;
         $display("FAIL %s: element slot %0d got %h expected %h",
                  name, slot, act[slot*DW +: DW], exp[slot*DW +: DW]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   vec_t  tbl [8];
   beat_t q [$];
   beat_t nb;
   mat_t  m1, m2, pm;
   logic  have_pend, exp_done, exp_vld, exp_rdy;

   initial begin
      tbl[0] = '{1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 0};
      tbl[1] = '{1'b0, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0, 1};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0, 1};
      tbl[3] = '{1'b0, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0, 1};
      tbl[4] = '{1'b1, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0, 1};
      tbl[5] = '{1'b1, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0, 2};
      tbl[6] = '{1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, -1};
      tbl[7] = '{1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, -1};

      rst = 1'b1;
      a_in_valid = 1'b1; b_in_valid = 1'b1;
      a_out_ready = 1'b0; b_out_ready = 1'b0;
      a_in_matrix = '0; b_in_matrix = '0;
      tick();

      // reset held with in_valid high
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("rst_a_in_ready", a_in_ready, 0);
         chk("rst_b_in_ready", b_in_ready, 0);
         chk("rst_a_out_valid", a_out_valid, 0);
         chk("rst_b_out_valid", b_out_valid, 0);
         chk("rst_a_done", a_done, 0);
         chk("rst_b_done", b_done, 0);
         tick();
      end
      rst = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0;
      #1;
      chk("post_rst_a_in_ready", a_in_ready, 1);
      chk("post_rst_b_in_ready", b_in_ready, 1);
      chk("post_rst_b_out_valid", b_out_valid, 0);
      tick();

      // single-beat default geometry
      m1 = pattern(16'h0000);
      a_in_matrix = pack(m1); a_in_valid = 1'b1; a_out_ready = 1'b1;
      #1;
      chk("a_cap_in_ready", a_in_ready, 1);
      tick();
      a_in_valid = 1'b0;
      #1;
      chk("a_beat_valid", a_out_valid, 1);
      chk("a_beat_base", a_out_col_base, 0);
      chk("a_beat_last", a_out_last, 1);
      chk("a_beat_done", a_done, 0);
      chk_cols("a_beat_cols", a_out_cols, beat_vec(m1, 0, 10));
      chk("a_lane0_row0", a_out_cols[9*LW + 15*DW +: DW], 32'h0000);
      chk("a_lane9_row15", a_out_cols[0 +: DW], 32'h0F09);
      tick();
      #1;
      chk("a_done_pulse", a_done, 1);
      chk("a_idle_valid", a_out_valid, 0);
      chk("a_idle_cols_zero", 32'(a_out_cols == '0), 1);
      tick();
      #1;
      chk("a_done_clear", a_done, 0);

      // LANES=4 stream with a 3-cycle stall on beat 1
      b_in_matrix = pack(m1); b_in_valid = 1'b1; b_out_ready = 1'b0;
      #1;
      chk("b_cap_in_ready", b_in_ready, 1);
      tick();
      b_in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         b_out_ready = tbl[i].rdy;
         #1;
         chk($sformatf("tbl%0d_valid", i), b_out_valid, 32'(tbl[i].exp_valid));
         chk($sformatf("tbl%0d_in_ready", i), b_in_ready, 32'(tbl[i].exp_in_ready));
         chk($sformatf("tbl%0d_base", i), b_out_col_base, 32'(tbl[i].exp_base));
         chk($sformatf("tbl%0d_last", i), b_out_last, 32'(tbl[i].exp_last));
         chk($sformatf("tbl%0d_done", i), b_done, 32'(tbl[i].exp_done));
         if (tbl[i].exp_beat >= 0)
            chk_cols($sformatf("tbl%0d_cols", i), widen_b(b_out_cols), beat_vec(m1, tbl[i].exp_beat, 4));
         else
            chk_cols($sformatf("tbl%0d_cols_zero", i), widen_b(b_out_cols), '0);
         if (tbl[i].exp_beat == 2) begin
            chk("b_col9_row2", b_out_cols[2*LW + 13*DW +: DW], 32'h0209);
            chk("b_lanes23_zero", 32'(b_out_cols[2*LW-1:0] == '0), 1);
         end
         tick();
      end

      // back-to-back matrices, in_valid high throughout
      m1 = pattern(16'h0000);
      m2 = pattern(16'h1000);
      b_in_matrix = pack(m1); b_in_valid = 1'b1; b_out_ready = 1'b1;
      #1;
      chk("b2b_cap1", b_in_ready, 1);
      tick();
      b_in_matrix = pack(m2);
      for (int b = 0; b < 3; b++) begin
         #1;
         chk($sformatf("b2b_m1_valid%0d", b), b_out_valid, 1);
         chk($sformatf("b2b_m1_base%0d", b), b_out_col_base, 32'(b*4));
         chk($sformatf("b2b_m1_in_ready%0d", b), b_in_ready, 32'(b == 2));
         chk_cols($sformatf("b2b_m1_cols%0d", b), widen_b(b_out_cols), beat_vec(m1, b, 4));
         tick();
      end
      b_in_valid = 1'b0;
      #1;
      chk("b2b_m2_valid0", b_out_valid, 1);
      chk("b2b_m2_base0", b_out_col_base, 0);
      chk("b2b_done_between", b_done, 1);
      chk_cols("b2b_m2_cols0", widen_b(b_out_cols), beat_vec(m2, 0, 4));
      tick();
      for (int b = 1; b < 3; b++) begin
         #1;
         chk($sformatf("b2b_m2_done_low%0d", b), b_done, 0);
         chk($sformatf("b2b_m2_base%0d", b), b_out_col_base, 32'(b*4));
         chk_cols($sformatf("b2b_m2_cols%0d", b), widen_b(b_out_cols), beat_vec(m2, b, 4));
         tick();
      end
      #1;
      chk("b2b_final_done", b_done, 1);
      chk("b2b_final_idle", b_out_valid, 0);
      tick();

      // reset in the middle of a stream
      m1 = pattern(16'h2000);
      b_in_matrix = pack(m1); b_in_valid = 1'b1; b_out_ready = 1'b1;
      tick();
      b_in_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", b_out_valid, 0);
      chk("mid_rst_in_ready", b_in_ready, 0);
      tick();
      rst = 1'b0; b_out_ready = 1'b0;
      #1;
      chk("after_rst_valid", b_out_valid, 0);
      chk("after_rst_done", b_done, 0);
      chk("after_rst_in_ready", b_in_ready, 1);
      m2 = pattern(16'h3000);
      b_in_matrix = pack(m2); b_in_valid = 1'b1;
      tick();
      b_in_valid = 1'b0;
      #1;
      chk("restream_valid", b_out_valid, 1);
      chk("restream_base", b_out_col_base, 0);
      chk_cols("restream_cols", widen_b(b_out_cols), beat_vec(m2, 0, 4));
      b_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();

      // randomized traffic against a queue of expected beats
      have_pend = 1'b0;
      exp_done = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!have_pend && $urandom_range(0, 2) == 0) begin
            pm = rand_mat();
            have_pend = 1'b1;
         end
         b_in_valid  = have_pend;
         b_in_matrix = have_pend ? pack(pm) : '0;
         b_out_ready = ($urandom_range(0, 3) != 0);
         #1;
         exp_vld = (q.size() != 0);
         exp_rdy = (q.size() == 0) || (q.size() == 1 && b_out_ready);
         chk("rand_valid", b_out_valid, 32'(exp_vld));
         chk("rand_in_ready", b_in_ready, 32'(exp_rdy));
         chk("rand_done", b_done, 32'(exp_done));
         if (exp_vld) begin
            chk("rand_base", b_out_col_base, 32'(q[0].base));
            chk("rand_last", b_out_last, 32'(q[0].last));
            chk_cols("rand_cols", widen_b(b_out_cols), widen_b(q[0].cols));
         end
         exp_done = 1'b0;
         if (exp_vld && b_out_ready) begin
            exp_done = q[0].last;
            void'(q.pop_front());
         end
         if (have_pend && exp_rdy) begin
            for (int b = 0; b < 3; b++) begin
               nb.cols = WB'(beat_vec(pm, b, 4));
               nb.base = 4'(b * 4);
               nb.last = (b == 2);
               q.push_back(nb);
            end
            have_pend = 1'b0;
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
